rvfi_retire_serializer: RTL and testbench
=========================================

# rvfi_retire_serializer

Sequencer between a multi-retire core's RVFI port and single-channel checkers such as the instruction-memory consistency check. Each cycle it captures up to NRET retired instructions and queues them in channel-index order. It replays them one per handshake on a single output channel. It also flags lost retirements and gaps in instruction order, so single-channel checks can be used on superscalar cores without per-channel replication.

## Interface
Parameters:
- NRET, 2: number of RVFI retire channels, 1..4
- XLEN, 32: architectural register and PC width
- DEPTH, 8: queue entries, power of two, ≥ NRET

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- rvfi_valid  in  NRET  per-channel retire strobe
- rvfi_order  in  NRET*8  per-channel retire order, wraps mod 256
- rvfi_insn  in  NRET*32  per-channel instruction word
- rvfi_pre_pc  in  NRET*XLEN  per-channel PC of the instruction
- rvfi_trap  in  NRET  per-channel trap flag
- out_valid  out  1  queue head valid
- out_ready  in  1  consumer accepts head
- out_order  out  8  head order
- out_insn  out  32  head instruction
- out_pc  out  XLEN  head PC
- out_trap  out  1  head trap flag
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a retire cycle was dropped
- order_error  out  1  sticky: popped order not previous+1

## Operation
- Push:
  - n = popcount(rvfi_valid).
  - If n > 0 and n ≤ DEPTH − level, valid channels are written in ascending channel index to consecutive slots.
  - Invalid channels are skipped; there are no holes.
- Drop:
  - If n > DEPTH − level, the whole cycle is dropped; no partial writes.
  - overflow sets the same edge.
  - There is no backpressure toward the core.
- Free space uses level before any same-cycle pop. This is deliberately conservative, so a full queue with a simultaneous pop still drops.
- Pop: out_valid && out_ready advances the head by one entry.
- Simultaneous push and pop: level_next = level + n − 1.
- Order tracking:
  - The first pop after reset loads expected = out_order + 1 and does not check.
  - Each later pop compares out_order against expected and sets order_error on mismatch. It then loads expected = out_order + 1 (mod 256), which resynchronises after one error.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from level, never from pointer equality.
- Sticky flags clear only on reset.
- Reset mid-operation discards all queued entries and clears the first-pop flag.

## Timing
- Reset values (the cycle after reset is sampled high):
  - out_valid=0, level=0, overflow=0, order_error=0.
  - out_order, out_insn, out_pc, out_trap = 0.
- Push latency: retirements sampled at edge N appear on out_valid/out_* at cycle N+1 when the queue was empty.
- Outputs are registered or read from registered storage. There is no combinational path from rvfi_* to out_*.
- Out fields hold stable while out_valid && !out_ready.
- Throughput: one pop per cycle. Sustained input above one per cycle overflows by design.
- level reflects both push and pop of edge N in cycle N+1.

## Structure
- Shared package rvfi_pkg:
  - rvfi_entry_t typedef: order, insn, pc, trap.
  - ORDER_W=8 constant, reused by other RVFI checkers.
- Sub-module rvfi_entry_fifo:
  - Multi-write, single-read circular buffer with parameters WR_PORTS=NRET and DEPTH.
  - Exposes level, write-count input and pop input.
- Top level holds compaction (prefix popcount over rvfi_valid), the drop decision, order tracking and sticky flags.

## Test plan
- Single push, empty queue, NRET=2: rvfi_valid=2'b10, order=5, pc=0x100 at cycle 0 → out_valid=1 at cycle 1 with out_order=5, out_pc=0x100; level=1.
- Compaction: rvfi_valid=2'b11, orders 7 (ch0) and 8 (ch1), out_ready=1 → pops 7 then 8 on consecutive cycles; order_error stays 0.
- Overflow, DEPTH=8, out_ready=0: fill to level=7, then present rvfi_valid=2'b11 → no write, level stays 7, overflow=1. A following single-channel push still succeeds, reaching level=8.
- Full with simultaneous pop: level=8, out_ready=1, one channel valid → push dropped, overflow=1, level=7.
- Order gap with wrap: pop orders 254, 255, 0, 2 → order_error stays 0 through 0, sets on 2. A following pop of 3 raises no new mismatch.
- Reset mid-operation: reset=1 for one cycle at level=5 with overflow=1 → next cycle level=0, out_valid=0, flags 0. The next first pop of any order does not set order_error.

Source files
------------

// File: rtl/rvfi_pkg.sv
// Shared RVFI types and constants used by the retire serializer and other
// single-channel RVFI checkers.
package rvfi_pkg;

  localparam int ORDER_W  = 8;
  localparam int INSN_W   = 32;
  localparam int PC_MAX_W = 64;

  // pc is stored at the widest supported XLEN and truncated at the consumer
  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [INSN_W-1:0]   insn;
    logic [PC_MAX_W-1:0] pc;
    logic                trap;
  } rvfi_entry_t;

  function automatic logic [ORDER_W-1:0] next_order(input logic [ORDER_W-1:0] order);
    return order + ORDER_W'(1);
  endfunction

endpackage

// File: rtl/rvfi_retire_serializer_if.sv
// Bundle of the multi-channel RVFI retire inputs and the single replay channel.
interface rvfi_retire_serializer_if #(
  parameter int NRET = 2,
  parameter int XLEN = 32
);
  import rvfi_pkg::*;

  logic [NRET-1:0]         rvfi_valid;
  logic [NRET*ORDER_W-1:0] rvfi_order;
  logic [NRET*INSN_W-1:0]  rvfi_insn;
  logic [NRET*XLEN-1:0]    rvfi_pre_pc;
  logic [NRET-1:0]         rvfi_trap;

  logic                    out_valid;
  logic                    out_ready;
  logic [ORDER_W-1:0]      out_order;
  logic [INSN_W-1:0]       out_insn;
  logic [XLEN-1:0]         out_pc;
  logic                    out_trap;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_pre_pc, rvfi_trap, out_ready,
    input  out_valid, out_order, out_insn, out_pc, out_trap
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_pre_pc, rvfi_trap, out_ready,
    output out_valid, out_order, out_insn, out_pc, out_trap
  );

endinterface

// File: rtl/rvfi_entry_fifo.sv
// Circular buffer accepting up to WR_PORTS compacted entries per cycle and
// releasing one entry per pop; occupancy is tracked by an explicit level.
module rvfi_entry_fifo
  import rvfi_pkg::*;
#(
  parameter int WR_PORTS = 2,
  parameter int DEPTH    = 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = PTR_W + 1,
  localparam int CNT_W   = $clog2(WR_PORTS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CNT_W-1:0]           wr_count,
  input  rvfi_entry_t [WR_PORTS-1:0] wr_data,
  input  logic                       pop,
  output rvfi_entry_t                rd_data,
  output logic [LVL_W-1:0]           level
);

  rvfi_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign pop_ok  = pop && (level != '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_count);
      rd_ptr <= rd_ptr + PTR_W'(pop_ok);
      level  <= level + LVL_W'(wr_count) - LVL_W'(pop_ok);
    end
  end

  // Storage write of the first wr_count slots into consecutive entries
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (CNT_W'(i) < wr_count) begin
        mem[wr_ptr + PTR_W'(i)] <= wr_data[i];
      end
    end
  end

endmodule

// File: rtl/rvfi_retire_serializer.sv
// Serializes up to NRET RVFI retirements per cycle onto one handshake channel,
// flagging dropped retire cycles and breaks in the popped order sequence.
module rvfi_retire_serializer
  import rvfi_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  localparam int LVL_W  = $clog2(DEPTH) + 1,
  localparam int CNT_W  = $clog2(NRET + 1)
) (
  input  logic                clk,
  input  logic                reset,
  rvfi_retire_serializer_if.slave bus,
  output logic [LVL_W-1:0]    level,
  output logic                overflow,
  output logic                order_error
);

  rvfi_entry_t [NRET-1:0] chan;
  rvfi_entry_t [NRET-1:0] compact;
  logic [CNT_W-1:0]       prefix [NRET];
  logic [CNT_W-1:0]       n;
  logic [LVL_W-1:0]       free;
  logic                   accept;
  logic                   drop;
  logic [CNT_W-1:0]       wr_count;
  logic                   pop;
  rvfi_entry_t            head_raw;
  rvfi_entry_t            head;
  logic                   first_done;
  logic [ORDER_W-1:0]     expected;

  // Unpack each retire channel into an entry
  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      chan[c].order = bus.rvfi_order[c*ORDER_W +: ORDER_W];
      chan[c].insn  = bus.rvfi_insn[c*INSN_W +: INSN_W];
      chan[c].pc    = PC_MAX_W'(bus.rvfi_pre_pc[c*XLEN +: XLEN]);
      chan[c].trap  = bus.rvfi_trap[c];
    end
  end

  // Exclusive prefix popcount: slot index of each valid channel
  always_comb begin
    n = '0;
    for (int c = 0; c < NRET; c++) begin
      prefix[c] = n;
      n         = n + CNT_W'(bus.rvfi_valid[c]);
    end
  end

  // Compaction: valid channels land in ascending slots with no holes
  always_comb begin
    compact = '0;
    for (int s = 0; s < NRET; s++) begin
      for (int c = 0; c < NRET; c++) begin
        if (bus.rvfi_valid[c] && (prefix[c] == CNT_W'(s))) begin
          compact[s] = chan[c];
        end else begin
          compact[s] = compact[s];
        end
      end
    end
  end

  // Free space ignores a same-cycle pop, so a full queue drops even while draining
  assign free     = LVL_W'(DEPTH) - level;
  assign accept   = (n != '0) && (LVL_W'(n) <= free);
  assign drop     = (LVL_W'(n) > free);
  assign wr_count = accept ? n : '0;
  assign pop      = bus.out_valid && bus.out_ready;

  rvfi_entry_fifo #(
    .WR_PORTS (NRET),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_count (wr_count),
    .wr_data  (compact),
    .pop      (pop),
    .rd_data  (head_raw),
    .level    (level)
  );

  // Storage is not cleared on reset, so the head is masked while empty
  assign bus.out_valid = (level != '0);
  assign head          = bus.out_valid ? head_raw : '0;
  assign bus.out_order = head.order;
  assign bus.out_insn  = head.insn;
  assign bus.out_pc    = head.pc[XLEN-1:0];
  assign bus.out_trap  = head.trap;

  // Sticky flags and expected-order tracking; first pop only seeds expected
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow    <= 1'b0;
      order_error <= 1'b0;
      first_done  <= 1'b0;
      expected    <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        if (first_done && (bus.out_order != expected)) begin
          order_error <= 1'b1;
        end
        expected   <= next_order(bus.out_order);
        first_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Randomized and directed bench for rvfi_retire_serializer against a queue-based
// reference model of the retire/replay behaviour.
module tb_rvfi_retire_serializer;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct {
    bit [7:0]  order;
    bit [31:0] insn;
    bit [31:0] pc;
    bit        trap;
  } ent_t;

  logic             clk;
  logic             reset;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             order_error;

  rvfi_retire_serializer_if #(.NRET(NRET), .XLEN(XLEN)) bus ();

  rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .level       (level),
    .overflow    (overflow),
    .order_error (order_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  ent_t     q[$];
  bit       m_ovf;
  bit       m_oerr;
  bit       m_first;
  bit [7:0] m_exp;
  bit [7:0] ord_ctr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_ch(input int c, input bit v, input bit [7:0] ord,
                        input bit [31:0] insn, input bit [31:0] pc, input bit trap);
    bus.rvfi_valid[c]          = v;
    bus.rvfi_order[c*8 +: 8]   = ord;
    bus.rvfi_insn[c*32 +: 32]  = insn;
    bus.rvfi_pre_pc[c*32 +: 32] = pc;
    bus.rvfi_trap[c]           = trap;
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < NRET; c++) set_ch(c, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Reference: pop from pre-edge head, then push whole cycle only if it fits in pre-edge space
  task automatic model_update();
    int   n;
    int   free;
    ent_t e;
    n = 0;
    for (int c = 0; c < NRET; c++) if (bus.rvfi_valid[c]) n++;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0; m_oerr = 1'b0; m_first = 1'b0; m_exp = 8'd0;
    end else begin
      free = DEPTH - q.size();
      if (q.size() > 0 && bus.out_ready) begin
        e = q.pop_front();
        if (m_first && e.order != m_exp) m_oerr = 1'b1;
        m_exp   = e.order + 8'd1;
        m_first = 1'b1;
      end
      if (n > free) begin
        m_ovf = 1'b1;
      end else begin
        for (int c = 0; c < NRET; c++) begin
          if (bus.rvfi_valid[c]) begin
            e.order = bus.rvfi_order[c*8 +: 8];
            e.insn  = bus.rvfi_insn[c*32 +: 32];
            e.pc    = bus.rvfi_pre_pc[c*32 +: 32];
            e.trap  = bus.rvfi_trap[c];
            q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("level", 64'(level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("order_error", 64'(order_error), 64'(m_oerr));
    if (q.size() != 0) begin
      chk("out_order", 64'(bus.out_order), 64'(q[0].order));
      chk("out_insn", 64'(bus.out_insn), 64'(q[0].insn));
      chk("out_pc", 64'(bus.out_pc), 64'(q[0].pc));
      chk("out_trap", 64'(bus.out_trap), 64'(q[0].trap));
    end else begin
      chk("idle_fields", {bus.out_order, bus.out_insn, bus.out_pc[23:0]}, 64'd0);
      chk("idle_trap", 64'(bus.out_trap), 64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic push1(input bit [7:0] ord);
    idle_inputs();
    set_ch(0, 1'b1, ord, 32'h0000_0013 + 32'(ord), 32'h1000 + 32'(ord) * 4, 1'b0);
    step();
  endtask

  task automatic push2(input bit [7:0] o0, input bit [7:0] o1);
    idle_inputs();
    set_ch(0, 1'b1, o0, 32'hA000_0000 + 32'(o0), 32'h2000 + 32'(o0) * 4, 1'b0);
    set_ch(1, 1'b1, o1, 32'hB000_0000 + 32'(o1), 32'h2000 + 32'(o1) * 4, 1'b1);
    step();
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_valid", 64'(bus.out_valid), 64'd0);

    // single push on channel 1
    idle_inputs();
    set_ch(1, 1'b1, 8'd5, 32'h0000_0093, 32'h100, 1'b0);
    step();
    chk("single_order", 64'(bus.out_order), 64'd5);
    chk("single_pc", 64'(bus.out_pc), 64'h100);
    chk("single_level", 64'(level), 64'd1);

    // compaction, consecutive pops
    do_reset();
    bus.out_ready = 1'b1;
    push2(8'd7, 8'd8);
    chk("compact_first", 64'(bus.out_order), 64'd7);
    idle_inputs();
    step();
    chk("compact_second", 64'(bus.out_order), 64'd8);
    step();
    chk("compact_oerr", 64'(order_error), 64'd0);

    // overflow, then a fitting single push, then full with simultaneous pop
    do_reset();
    for (int i = 0; i < 7; i++) push1(8'(i));
    chk("fill_level", 64'(level), 64'd7);
    push2(8'd7, 8'd8);
    chk("ovf_level", 64'(level), 64'd7);
    chk("ovf_flag", 64'(overflow), 64'd1);
    push1(8'd7);
    chk("after_ovf_level", 64'(level), 64'd8);
    bus.out_ready = 1'b1;
    push1(8'd8);
    chk("full_pop_level", 64'(level), 64'd7);
    idle_inputs();
    step();
    step();
    chk("pre_reset_level", 64'(level), 64'd5);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_level", 64'(level), 64'd0);
    chk("midreset_ovf", 64'(overflow), 64'd0);
    push1(8'd99);
    bus.out_ready = 1'b1;
    idle_inputs();
    step();
    chk("first_pop_oerr", 64'(order_error), 64'd0);

    // order gap across the wrap
    do_reset();
    push2(8'd254, 8'd255);
    push2(8'd0, 8'd2);
    push1(8'd3);
    bus.out_ready = 1'b1;
    idle_inputs();
    step(); step(); step();
    chk("wrap_ok", 64'(order_error), 64'd0);
    step();
    chk("gap_flag", 64'(order_error), 64'd1);
    step();

    // randomized traffic
    do_reset();
    ord_ctr = 8'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 599) == 0);
      bus.out_ready = ($urandom_range(0, 99) < 60);
      for (int c = 0; c < NRET; c++) begin
        if ($urandom_range(0, 99) < 40) begin
          set_ch(c, 1'b1, ord_ctr, $urandom, $urandom, 1'($urandom_range(0, 1)));
          ord_ctr = ord_ctr + (($urandom_range(0, 29) == 0) ? 8'd2 : 8'd1);
        end else begin
          set_ch(c, 1'b0, 8'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
      end
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
